// File: rtl/conv_weight_loader.sv
// Runtime weight store for the conv layer: takes a valid/ready stream of weight/bias words
// into a 64-entry RAM and serves a combinational ROM-style read port. Optional macro: WEIGHT_CHECKSUM_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_weight_loader #(
  parameter int KERNEL_SIZE = 3,
  parameter int KERNEL_NUM  = 2,
  parameter int WEIGHT_NUM  = KERNEL_NUM * (KERNEL_SIZE * KERNEL_SIZE + 1),
  parameter int DEPTH       = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_conv_busy,
  input  logic [`DATA_WIDTH-1:0] i_wr_data,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  output logic [5:0]             o_wr_count,
  output logic                   o_load_done,
  input  logic [5:0]             i_rd_addr,
  output logic [`DATA_WIDTH-1:0] o_rd_data,
  output logic [`DATA_WIDTH-1:0] o_checksum,
  output logic [1:0]             o_dbg_state
);

  localparam int W = `DATA_WIDTH;
  localparam logic [5:0] LAST_ADDR = 6'(WEIGHT_NUM - 1);
  localparam logic [6:0] NUM_EXT   = 7'(WEIGHT_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [5:0]    wr_addr;
  logic          xfer;
  logic [W-1:0]  mem [DEPTH];

  // Handshake: a word moves on a rising edge where i_wr_valid && o_wr_ready. Ready depends only on
  // state and i_conv_busy, never on valid; a start pulse on the same edge wins and the word is dropped.
  assign xfer = (state_q == LOAD) && i_wr_valid && !i_conv_busy && !i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    o_wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD;
      end
      LOAD: begin
        o_wr_ready = !i_conv_busy;
        if (i_start)                          state_d = LOAD;
        else if (xfer && wr_addr == LAST_ADDR) state_d = DONE;
      end
      DONE: begin
        if (i_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      o_wr_count  <= '0;
      o_load_done <= 1'b0;
    end else if (i_start) begin
      wr_addr     <= '0;
      o_wr_count  <= '0;
      o_load_done <= 1'b0;
    end else if (xfer) begin
      wr_addr    <= wr_addr + 6'd1;
      o_wr_count <= o_wr_count + 6'd1;
      if (wr_addr == LAST_ADDR) o_load_done <= 1'b1;
    end
  end

  // RAM contents survive reset so a reset mid-load leaves earlier words in place.
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_addr] <= i_wr_data;
  end

  assign o_rd_data = ({1'b0, i_rd_addr} < NUM_EXT) ? mem[i_rd_addr] : '0;

`ifdef WEIGHT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       o_checksum <= '0;
    else if (i_start) o_checksum <= '0;
    else if (xfer)    o_checksum <= o_checksum + i_wr_data;
  end
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: streamed loads with busy stalls, restart, reset mid-load,
// read-port table and checksum, checked through an expected-data queue.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_conv_weight_loader;

  localparam int W  = `DATA_WIDTH;
  localparam int NW = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_conv_busy = 1'b0;
  logic [W-1:0] i_wr_data = '0;
  logic         i_wr_valid = 1'b0;
  logic         o_wr_ready;
  logic [5:0]   o_wr_count;
  logic         o_load_done;
  logic [5:0]   i_rd_addr = '0;
  logic [W-1:0] o_rd_data;
  logic [W-1:0] o_checksum;
  logic [1:0]   o_dbg_state;

  int total = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [5:0]   addr;
    logic [W-1:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tab[6];

  conv_weight_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_conv_busy (i_conv_busy),
    .i_wr_data   (i_wr_data),
    .i_wr_valid  (i_wr_valid),
    .o_wr_ready  (o_wr_ready),
    .o_wr_count  (o_wr_count),
    .o_load_done (o_load_done),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_checksum  (o_checksum),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver: start pulse carries a junk word that must never be written
  task automatic pulse_start();
    i_start    = 1'b1;
    i_wr_valid = 1'b1;
    i_wr_data  = W'(32'hDEAD_BEEF);
    tick();
    i_start    = 1'b0;
    i_wr_valid = 1'b0;
    chk("start_count", W'(o_wr_count), W'(0));
    chk("start_done", W'(o_load_done), W'(0));
    chk("start_checksum", o_checksum, W'(0));
    chk("start_state", W'(o_dbg_state), W'(1));
  endtask

  // driver: stream n words base+i, with i_conv_busy high for cycles [bs, bs+bl)
  task automatic load_words(input logic [W-1:0] base, input int n, input int bs, input int bl);
    int idx = 0;
    int c = 0;
    bit acc;
    while (idx < n && c < 200) begin
      i_conv_busy = (c >= bs) && (c < bs + bl);
      i_wr_valid  = 1'b1;
      i_wr_data   = base + W'(idx);
      #1;
      chk("wr_ready", W'(o_wr_ready), W'(!i_conv_busy));
      acc = !i_conv_busy;
      if (n == NW && idx == n - 1) chk("done_early", W'(o_load_done), W'(0));
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(base + W'(idx));
        idx++;
      end
      chk("wr_count", W'(o_wr_count), W'(idx));
      c++;
    end
    i_wr_valid  = 1'b0;
    i_conv_busy = 1'b0;
    chk("load_finished", W'(idx), W'(n));
    if (n == NW) begin
      chk("load_done", W'(o_load_done), W'(1));
      chk("done_state", W'(o_dbg_state), W'(2));
      chk("done_ready", W'(o_wr_ready), W'(0));
    end
  endtask

  // scoreboard: read back the current load and pop expected words
  task automatic verify(input int n);
    for (int a = 0; a < n; a++) begin
      i_rd_addr = 6'(a);
      #1;
      if (exp_q.size() == 0) chk("sb_underflow", W'(1), W'(0));
      else chk("readback", o_rd_data, exp_q.pop_front());
    end
    chk("sb_leftover", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    rd_tab[0] = '{addr: 6'd20, exp: W'(0)};
    rd_tab[1] = '{addr: 6'd63, exp: W'(0)};
    rd_tab[2] = '{addr: 6'd5,  exp: W'(32'h1005)};
    rd_tab[3] = '{addr: 6'd0,  exp: W'(32'h1000)};
    rd_tab[4] = '{addr: 6'd19, exp: W'(32'h1013)};
    rd_tab[5] = '{addr: 6'd21, exp: W'(0)};

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", W'(o_wr_ready), W'(0));
    chk("rst_count", W'(o_wr_count), W'(0));
    chk("rst_done", W'(o_load_done), W'(0));
    chk("rst_checksum", o_checksum, W'(0));
    chk("rst_state", W'(o_dbg_state), W'(0));

    // full load with valid held high
    pulse_start();
    load_words(W'(32'h1000), NW, 1000, 0);
    repeat (3) tick();
    chk("done_held", W'(o_load_done), W'(1));
    chk("count_held", W'(o_wr_count), W'(NW));
    verify(NW);

    for (int i = 0; i < 6; i++) begin
      i_rd_addr = rd_tab[i].addr;
      #1;
      chk("rd_table", o_rd_data, rd_tab[i].exp);
    end

    // same load stalled by conv busy for 5 cycles
    pulse_start();
    load_words(W'(32'h1000), NW, 6, 5);
    verify(NW);

    // partial load, restart, full load
    pulse_start();
    load_words(W'(32'hA000), 8, 1000, 0);
    exp_q.delete();
    pulse_start();
    load_words(W'(32'hA000), NW, 1000, 0);
    verify(NW);

    // checksum of words 1..20
    pulse_start();
    load_words(W'(1), NW, 1000, 0);
`ifdef WEIGHT_CHECKSUM_EN
    chk("checksum", o_checksum, W'(210));
`else
    chk("checksum", o_checksum, W'(0));
`endif
    repeat (3) tick();
`ifdef WEIGHT_CHECKSUM_EN
    chk("checksum_held", o_checksum, W'(210));
`else
    chk("checksum_held", o_checksum, W'(0));
`endif
    verify(NW);

    // reset after 10 words; address 10 keeps the value 11 from the previous load
    pulse_start();
    load_words(W'(32'h5000), 10, 1000, 0);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_done", W'(o_load_done), W'(0));
    chk("midrst_ready", W'(o_wr_ready), W'(0));
    chk("midrst_count", W'(o_wr_count), W'(0));
    chk("midrst_state", W'(o_dbg_state), W'(0));
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = W'(32'hBEEF) + W'(k);
      tick();
      chk("idle_ready", W'(o_wr_ready), W'(0));
      chk("idle_count", W'(o_wr_count), W'(0));
    end
    i_wr_valid = 1'b0;
    i_rd_addr = 6'd10;
    #1;
    chk("addr10_kept", o_rd_data, W'(11));
    i_rd_addr = 6'd9;
    #1;
    chk("addr9_written", o_rd_data, W'(32'h5009));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
